// File: rtl/mackerel_bus_pkg.sv
// Shared types and default constants for the mackerel bus acknowledge stage.
// Optional feature macro: MACKEREL_AUTOVECTOR_EN (IACK cycles autovector via /VPA).
package mackerel_bus_pkg;

    // Acknowledge FSM states; encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Source latched at cycle start.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_ROM  = 3'd1,
        SRC_RAM  = 3'd2,
        SRC_USB  = 3'd3,
        SRC_SER  = 3'd4,
        SRC_MFP  = 3'd5,
        SRC_AVEC = 3'd6
    } src_t;

    localparam int CNT_W            = 8;
    localparam int DEF_ROM_WAIT     = 2;
    localparam int DEF_RAM_WAIT     = 0;
    localparam int DEF_USB_WAIT     = 3;
    localparam int DEF_TIMEOUT      = 64;

    // Sources whose acknowledge comes from the local wait counter
    // rather than from a device DTACK line.
    function automatic logic src_is_timed(input src_t s);
        return (s == SRC_ROM) || (s == SRC_RAM) || (s == SRC_USB) || (s == SRC_AVEC);
    endfunction

endpackage

// File: rtl/mackerel_bus_timer.sv
// Wait-state down-counter and cycle timeout up-counter for the acknowledge stage.
// Both counters are 8 bits and are loaded together at cycle start.
module mackerel_bus_timer
    import mackerel_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_run,
    output logic             o_wait_done,
    output logic             o_tmo_tc
);

    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] r_tmo;

    // Wait counter: load the region's wait count, then count down while waiting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait <= '0;
        end else if (i_load) begin
            r_wait <= i_load_val;
        end else if (i_run && (r_wait != '0)) begin
            r_wait <= r_wait - 1'b1;
        end
    end

    // Timeout counter: cleared at cycle start, counts up while waiting, saturates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo <= '0;
        end else if (i_load) begin
            r_tmo <= '0;
        end else if (i_run && (r_tmo != {CNT_W{1'b1}})) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // The decrement taken at this edge brings the wait count to zero.
    assign o_wait_done = (r_wait == CNT_W'(1));
    // The increment taken at this edge brings the timeout count to TIMEOUT-1.
    assign o_tmo_tc    = (r_tmo == CNT_W'(TIMEOUT - 2));

endmodule

// File: rtl/mackerel_bus_ack.sv
// 68000 bus-cycle acknowledge stage: inserts wait states for internally timed
// regions, forwards device DTACK for self-timed peripherals, and raises /BERR
// when a cycle is not acknowledged within TIMEOUT clocks.
// Optional feature macro: MACKEREL_AUTOVECTOR_EN -- IACK cycles answer with /VPA
// after USB_WAIT clocks instead of waiting on the MFP.
//
// Handshake: a cycle starts at the first edge in IDLE where AS is sampled low;
// the acknowledge (DTACK, BERR or VPA, exactly one, active low) is held until
// AS is sampled high, which releases it and returns to IDLE. AS sampled high
// before acknowledge aborts the cycle silently. A new cycle needs AS high for
// at least one edge, which the release edge itself provides.
// Legal parameters: TIMEOUT 4..255, every *_WAIT below TIMEOUT.
module mackerel_bus_ack
    import mackerel_bus_pkg::*;
#(
    parameter int ROM_WAIT = DEF_ROM_WAIT,
    parameter int RAM_WAIT = DEF_RAM_WAIT,
    parameter int USB_WAIT = DEF_USB_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       IACK,
    input  logic       ROMEN,
    input  logic       RAMEN,
    input  logic       USBEN,
    input  logic       SEREN,
    input  logic       MFPEN,
    input  logic       DTACK_MFP,
    input  logic       DTACK_SER,
    output logic       DTACK,
    output logic       BERR,
    output logic       VPA,
    output logic [1:0] o_dbg_state
);

    state_t           r_state;
    src_t             r_src;
    logic             r_dtack;
    logic             r_berr;
    logic             r_vpa;

    state_t           w_state_nxt;
    src_t             w_src_nxt;
    src_t             w_src_sel;
    logic [CNT_W-1:0] w_wait_sel;
    logic             w_load;
    logic             w_run;
    logic             w_ack_cond;
    logic             w_wait_done;
    logic             w_tmo_tc;

    mackerel_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .i_load      (w_load),
        .i_load_val  (w_wait_sel),
        .i_run       (w_run),
        .o_wait_done (w_wait_done),
        .o_tmo_tc    (w_tmo_tc)
    );

    // Source priority at cycle start; ROM beats RAM because they overlap at boot.
    always_comb begin
        w_src_sel  = SRC_NONE;
        w_wait_sel = '0;
        if (!IACK) begin
`ifdef MACKEREL_AUTOVECTOR_EN
            w_src_sel  = SRC_AVEC;
            w_wait_sel = CNT_W'(USB_WAIT);
`else
            w_src_sel  = SRC_MFP;
`endif
        end else if (!MFPEN) begin
            w_src_sel  = SRC_MFP;
        end else if (!SEREN) begin
            w_src_sel  = SRC_SER;
        end else if (!USBEN) begin
            w_src_sel  = SRC_USB;
            w_wait_sel = CNT_W'(USB_WAIT);
        end else if (!ROMEN) begin
            w_src_sel  = SRC_ROM;
            w_wait_sel = CNT_W'(ROM_WAIT);
        end else if (!RAMEN) begin
            w_src_sel  = SRC_RAM;
            w_wait_sel = CNT_W'(RAM_WAIT);
        end
    end

    // Acknowledge condition for the latched source while waiting.
    always_comb begin
        w_ack_cond = 1'b0;
        case (r_src)
            SRC_ROM, SRC_RAM, SRC_USB, SRC_AVEC: w_ack_cond = w_wait_done;
            SRC_SER:                             w_ack_cond = !DTACK_SER;
            SRC_MFP:                             w_ack_cond = !DTACK_MFP;
            default:                             w_ack_cond = 1'b0;
        endcase
    end

    // Next-state logic: abort beats acknowledge, acknowledge beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_load      = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!AS) begin
                    w_load    = 1'b1;
                    w_src_nxt = w_src_sel;
                    if (src_is_timed(w_src_sel) && (w_wait_sel == '0)) begin
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_run = 1'b1;
                if (AS) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ack_cond) begin
                    w_state_nxt = ST_ACK;
                end else if (w_tmo_tc) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ACK, ST_ERR: begin
                if (AS) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and latched source register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_src   <= SRC_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
        end
    end

    // Registered active-low DTACK/BERR decoded from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dtack <= 1'b1;
            r_berr  <= 1'b1;
        end else begin
            r_dtack <= !((w_state_nxt == ST_ACK) && (w_src_nxt != SRC_AVEC));
            r_berr  <= !(w_state_nxt == ST_ERR);
        end
    end

`ifdef MACKEREL_AUTOVECTOR_EN
    // Registered active-low VPA for autovectored interrupt acknowledge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_vpa <= 1'b1;
        end else begin
            r_vpa <= !((w_state_nxt == ST_ACK) && (w_src_nxt == SRC_AVEC));
        end
    end
`else
    // Autovectoring disabled: VPA never asserts.
    always_comb begin
        r_vpa = 1'b1;
    end
`endif

    assign DTACK       = r_dtack;
    assign BERR        = r_berr;
    assign VPA         = r_vpa;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mackerel_bus_ack.sv
// Directed testbench for mackerel_bus_ack (default parameters).
// Honours MACKEREL_AUTOVECTOR_EN for the IACK scenario.
module tb_mackerel_bus_ack;

    logic       CLK;
    logic       RST;
    logic       AS;
    logic       IACK;
    logic       ROMEN;
    logic       RAMEN;
    logic       USBEN;
    logic       SEREN;
    logic       MFPEN;
    logic       DTACK_MFP;
    logic       DTACK_SER;
    logic       DTACK;
    logic       BERR;
    logic       VPA;
    logic [1:0] dbg_state;

    int n_compared;
    int n_mismatched;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    mackerel_bus_ack dut (
        .CLK         (CLK),
        .RST         (RST),
        .AS          (AS),
        .IACK        (IACK),
        .ROMEN       (ROMEN),
        .RAMEN       (RAMEN),
        .USBEN       (USBEN),
        .SEREN       (SEREN),
        .MFPEN       (MFPEN),
        .DTACK_MFP   (DTACK_MFP),
        .DTACK_SER   (DTACK_SER),
        .DTACK       (DTACK),
        .BERR        (BERR),
        .VPA         (VPA),
        .o_dbg_state (dbg_state)
    );

    // Clock: 10 time-unit period; stimulus and sampling on the falling edge.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Bus quiescent: strobe and all selects/acks inactive.
    task automatic bus_idle();
        AS = 1'b1; IACK = 1'b1; ROMEN = 1'b1; RAMEN = 1'b1; USBEN = 1'b1;
        SEREN = 1'b1; MFPEN = 1'b1; DTACK_MFP = 1'b1; DTACK_SER = 1'b1;
    endtask

    // End the cycle at a falling edge and check release after the next rising edge.
    task automatic release_cycle(input string name);
        bus_idle();
        @(negedge CLK);
        n_compared++;
        if ({DTACK, BERR, VPA, dbg_state} !== {1'b1, 1'b1, 1'b1, S_IDLE}) begin
            n_mismatched++;
            $display("FAIL %s_release actual dtack/berr/vpa/state=%b%b%b/%0d required=111/0",
                     name, DTACK, BERR, VPA, dbg_state);
        end
    endtask

    task automatic test_reset();
        bus_idle();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        n_compared++;
        if ({DTACK, BERR, VPA, dbg_state} !== {1'b1, 1'b1, 1'b1, S_IDLE}) begin
            n_mismatched++;
            $display("FAIL reset_outputs actual dtack/berr/vpa/state=%b%b%b/%0d required=111/0",
                     DTACK, BERR, VPA, dbg_state);
        end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    // ROM read: DTACK low after E0+2; also ROM+RAM overlap with same timing.
    task automatic test_rom(input logic with_ram);
        logic exp;
        ROMEN = 1'b0; RAMEN = with_ram ? 1'b0 : 1'b1; AS = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge CLK);
            exp = (k >= 2) ? 1'b0 : 1'b1;
            n_compared++;
            if (DTACK !== exp || BERR !== 1'b1) begin
                n_mismatched++;
                $display("FAIL rom%s_dtack_e0+%0d actual dtack=%b berr=%b required dtack=%b berr=1",
                         with_ram ? "_ram" : "", k, DTACK, BERR, exp);
            end
        end
        release_cycle("rom");
    endtask

    // RAM read with zero wait states: DTACK low right after E0.
    task automatic test_ram();
        RAMEN = 1'b0; AS = 1'b0;
        @(negedge CLK);
        n_compared++;
        if (DTACK !== 1'b0 || dbg_state !== S_ACK) begin
            n_mismatched++;
            $display("FAIL ram_dtack_e0 actual dtack=%b state=%0d required dtack=0 state=2",
                     DTACK, dbg_state);
        end
        release_cycle("ram");
    endtask

    // MFP access: device ack sampled at E0+5; a stray DTACK_SER is ignored.
    task automatic test_mfp();
        MFPEN = 1'b0; AS = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge CLK);
            DTACK_SER = (k == 1) ? 1'b0 : 1'b1;
            n_compared++;
            if (DTACK !== 1'b1) begin
                n_mismatched++;
                $display("FAIL mfp_wait_e0+%0d actual dtack=%b required dtack=1", k, DTACK);
            end
        end
        DTACK_MFP = 1'b0;
        @(negedge CLK);
        n_compared++;
        if (DTACK !== 1'b0 || BERR !== 1'b1) begin
            n_mismatched++;
            $display("FAIL mfp_ack_e0+5 actual dtack=%b berr=%b required dtack=0 berr=1", DTACK, BERR);
        end
        release_cycle("mfp");
    endtask

    // Unmapped access: BERR after E0+63, held until AS rises.
    task automatic test_unmapped();
        AS = 1'b0;
        for (int k = 0; k <= 62; k++) begin
            @(negedge CLK);
            if (k == 0 || k == 62) begin
                n_compared++;
                if (BERR !== 1'b1 || DTACK !== 1'b1) begin
                    n_mismatched++;
                    $display("FAIL unmapped_wait_e0+%0d actual berr=%b dtack=%b required berr=1 dtack=1",
                             k, BERR, DTACK);
                end
            end
        end
        for (int k = 63; k <= 64; k++) begin
            @(negedge CLK);
            n_compared++;
            if (BERR !== 1'b0 || DTACK !== 1'b1 || dbg_state !== S_ERR) begin
                n_mismatched++;
                $display("FAIL unmapped_berr_e0+%0d actual berr=%b dtack=%b state=%0d required berr=0 dtack=1 state=3",
                         k, BERR, DTACK, dbg_state);
            end
        end
        release_cycle("unmapped");
    endtask

    // Device ack on the very edge the timeout would fire: acknowledge wins.
    task automatic test_ack_timeout_tie();
        MFPEN = 1'b0; AS = 1'b0;
        repeat (63) @(negedge CLK);
        DTACK_MFP = 1'b0;
        @(negedge CLK);
        n_compared++;
        if (DTACK !== 1'b0 || BERR !== 1'b1) begin
            n_mismatched++;
            $display("FAIL tie_e0+63 actual dtack=%b berr=%b required dtack=0 berr=1", DTACK, BERR);
        end
        release_cycle("tie");
    endtask

    // USB cycle aborted by AS rising at E0+1: no acknowledge, back to IDLE.
    task automatic test_abort();
        USBEN = 1'b0; AS = 1'b0;
        @(negedge CLK);
        n_compared++;
        if (dbg_state !== S_WAIT) begin
            n_mismatched++;
            $display("FAIL abort_wait actual state=%0d required state=1", dbg_state);
        end
        AS = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            n_compared++;
            if (DTACK !== 1'b1 || BERR !== 1'b1 || dbg_state !== S_IDLE) begin
                n_mismatched++;
                $display("FAIL abort_e0+%0d actual dtack=%b berr=%b state=%0d required dtack=1 berr=1 state=0",
                         k, DTACK, BERR, dbg_state);
            end
        end
        bus_idle();
    endtask

    // Reset mid-cycle (in WAIT, then in ACK) clears immediately; next cycle is normal.
    task automatic test_reset_midcycle();
        SEREN = 1'b0; AS = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        n_compared++;
        if (dbg_state !== S_IDLE || DTACK !== 1'b1) begin
            n_mismatched++;
            $display("FAIL rst_in_wait actual state=%0d dtack=%b required state=0 dtack=1", dbg_state, DTACK);
        end
        RST = 1'b1;
        @(negedge CLK);
        SEREN = 1'b0; AS = 1'b0;
        @(negedge CLK);
        DTACK_SER = 1'b0;
        @(negedge CLK);
        n_compared++;
        if (DTACK !== 1'b0) begin
            n_mismatched++;
            $display("FAIL ser_ack_e0+1 actual dtack=%b required dtack=0", DTACK);
        end
        #2 RST = 1'b0;
        #1;
        n_compared++;
        if (DTACK !== 1'b1 || dbg_state !== S_IDLE) begin
            n_mismatched++;
            $display("FAIL rst_in_ack actual dtack=%b state=%0d required dtack=1 state=0", DTACK, dbg_state);
        end
        bus_idle();
        #1 RST = 1'b1;
        @(negedge CLK);
        SEREN = 1'b0; AS = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        DTACK_SER = 1'b0;
        @(negedge CLK);
        n_compared++;
        if (DTACK !== 1'b0 || BERR !== 1'b1) begin
            n_mismatched++;
            $display("FAIL ser_after_rst_e0+2 actual dtack=%b berr=%b required dtack=0 berr=1", DTACK, BERR);
        end
        release_cycle("ser");
    endtask

    // IACK cycle: autovector after USB_WAIT, or wait on DTACK_MFP.
    task automatic test_iack();
        logic exp_v;
        logic exp_d;
        IACK = 1'b0; AS = 1'b0;
`ifdef MACKEREL_AUTOVECTOR_EN
        DTACK_MFP = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge CLK);
            exp_v = (k >= 3) ? 1'b0 : 1'b1;
            n_compared++;
            if (VPA !== exp_v || DTACK !== 1'b1 || BERR !== 1'b1) begin
                n_mismatched++;
                $display("FAIL iack_avec_e0+%0d actual vpa=%b dtack=%b berr=%b required vpa=%b dtack=1 berr=1",
                         k, VPA, DTACK, BERR, exp_v);
            end
        end
`else
        for (int k = 0; k <= 3; k++) begin
            @(negedge CLK);
            if (k == 1) DTACK_MFP = 1'b0;
            exp_d = (k >= 2) ? 1'b0 : 1'b1;
            n_compared++;
            if (DTACK !== exp_d || VPA !== 1'b1) begin
                n_mismatched++;
                $display("FAIL iack_mfp_e0+%0d actual dtack=%b vpa=%b required dtack=%b vpa=1",
                         k, DTACK, VPA, exp_d);
            end
        end
`endif
        release_cycle("iack");
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_rom(1'b0);
        test_ram();
        test_rom(1'b1);
        test_mfp();
        test_unmapped();
        test_ack_timeout_tie();
        test_abort();
        test_reset_midcycle();
        test_iack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
